mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between ICache miss refills and DCache miss refills/writebacks in the Riscv151 pipeline.
- Accepts one line-sized request at a time and runs it to completion.
  - Reads: BEATS response beats.
  - Writes: BEATS write-data beats.
- Uses round-robin arbitration.
- busy feeds the pipeline controller's stall logic.

Parameters:
ADDR_W, 28, line-granular memory address width
DATA_W, 128, width of one memory beat
BEATS, 4, beats per cache line; power of 2, >=1

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
ic_req_valid  in  1  ICache requests a line read
ic_req_ready  out  1  ICache request accepted this cycle
ic_req_addr  in  ADDR_W  ICache line address
ic_resp_valid  out  1  read beat for ICache
ic_resp_data  out  DATA_W  read beat data
dc_req_valid  in  1  DCache request
dc_req_ready  out  1  DCache request accepted this cycle
dc_req_addr  in  ADDR_W  DCache line address
dc_req_rw  in  1  1 = writeback, 0 = refill
dc_wdata_valid  in  1  DCache write beat valid
dc_wdata_ready  out  1  DCache write beat taken
dc_wdata  in  DATA_W  write beat data
dc_resp_valid  out  1  read beat for DCache
dc_resp_data  out  DATA_W  read beat data
mem_req_valid  out  1  command valid to memory
mem_req_ready  in  1  memory accepts command
mem_req_addr  out  ADDR_W  command address
mem_req_rw  out  1  1 = write
mem_req_data_valid  out  1  write beat valid
mem_req_data_ready  in  1  memory accepts write beat
mem_req_data  out  DATA_W  write beat data
mem_resp_valid  in  1  read beat from memory
mem_resp_data  in  DATA_W  read beat data
busy  out  1  transaction in progress (not IDLE)
owner  out  1  current/last grant: 0 = ICache, 1 = DCache

Behaviour:
- States:
  - IDLE → ISSUE: when any req_valid.
  - ISSUE → WRITE or READ: on mem_req_ready; WRITE if latched rw = 1, else READ.
  - WRITE → IDLE: on the BEATS-th data handshake.
  - READ → IDLE: on the BEATS-th mem_resp_valid.
- Reset (reset = 0, async):
  - state = IDLE, beat counter = 0, last_owner = ICache (0).
  - All valid/ready outputs 0, resp_data outputs 0, busy = 0, owner = 0.
  - Reset mid-transaction abandons it silently; no further resp/ready pulses are issued.
- Arbitration, IDLE only:
  - Single requester: it wins.
  - Both valid: the winner is the requester that is not last_owner.
  - Winner's req_ready = 1 for exactly that cycle (combinational on valid).
  - addr, and rw (forced 0 for ICache) are latched; owner/last_owner are updated.
  - Requests arriving outside IDLE see req_ready = 0 and must hold valid.
- ISSUE:
  - mem_req_valid = 1 with latched addr/rw, held stable until mem_req_ready.
  - Earliest command cycle is the cycle after acceptance.
- WRITE:
  - Combinational pass-through: mem_req_data_valid = dc_wdata_valid, dc_wdata_ready = mem_req_data_ready, mem_req_data = dc_wdata.
  - Beat counter increments on each valid&ready handshake.
  - Stalls on either side hold the counter.
- READ:
  - On mem_resp_valid, the owner's resp_valid = 1 and resp_data = mem_resp_data (combinational); the other requester sees valid = 0, data = 0.
  - Counter increments per beat.
- Counter:
  - Width max(1, clog2(BEATS)).
  - Final beat is counter == BEATS-1 with handshake; counter wraps to 0 on the same edge as the transition to IDLE.
  - BEATS = 1: single-beat transactions.
- mem_resp_valid outside READ, and data-ready outside WRITE, are ignored.
- Back-to-back:
  - After the final beat, IDLE lasts one cycle minimum; a new grant occurs in that IDLE cycle.
  - Turnaround: final beat → next mem_req_valid = 2 cycles.
- busy = (state != IDLE).

Decomposition:
- Shared header: state encodings (ARB_IDLE, ARB_ISSUE, ARB_WRITE, ARB_READ), owner constants (ARB_OWNER_IC = 0, ARB_OWNER_DC = 1), MEM_RW_READ/WRITE.
- State, counter and latch registers use the codebase's asynchronous active-low reset register primitive.
- No sub-module beyond that; the FSM and counter stay in one file.

Test Plan:
- ICache read alone: ic_req_valid, addr 0x0000010, mem_req_ready on 1st ISSUE cycle, 4 resp beats A0..A3 with gaps → ic_req_ready 1 cycle, mem_req_addr = 0x0000010, rw = 0, ic_resp_valid exactly 4 times with A0..A3, dc_resp_valid never, busy drops after A3.
- DCache writeback: rw = 1, addr 0x0000ABC, data D0..D3, mem_req_data_ready toggled 1/0 → exactly 4 data handshakes in order, dc_wdata_ready mirrors mem_req_data_ready, state returns to IDLE after D3.
- Contention: both valid from reset, held → grants in order DC, IC, DC, IC; each second grant waits for the previous transaction's last beat; owner matches the grant.
- Stray traffic: mem_resp_valid pulses during IDLE/ISSUE/WRITE → no resp_valid output, counter unchanged.
- Async reset asserted after 2 of 4 read beats → outputs 0 immediately; after release, a new IC request completes a full 4 beats.
- BEATS = 1 build: alternating IC read / DC write → one beat each, final-beat → next mem_req_valid spacing of 2 cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: FSM encodings, owner ids,
// memory command direction and the beat-counter width helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WRITE = 2'd2,
        ARB_READ  = 2'd3
    } arb_state_e;

    localparam logic ARB_OWNER_IC = 1'b0;
    localparam logic ARB_OWNER_DC = 1'b1;

    localparam logic MEM_RW_READ  = 1'b0;
    localparam logic MEM_RW_WRITE = 1'b1;

    // A single-beat line still needs a 1-bit counter so the datapath stays uniform
    function automatic int arb_cnt_width(input int beats);
        return (beats <= 2) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/mem_arbiter_reg.sv
// Plain D register with asynchronous active-low reset to a parameterised value.
module mem_arbiter_reg #(
    parameter int             W         = 1,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the main-memory port between ICache refills and
// DCache refills/writebacks; one line-sized transaction runs to completion at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_rw,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_rw,
    output logic              mem_req_data_valid,
    input  logic              mem_req_data_ready,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              busy,
    output logic              owner
);

    localparam int               CNT_W     = arb_cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [1:0]        state_bits_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              rw_q;
    logic              rw_d;
    logic              owner_q;
    logic              owner_d;

    logic              any_req;
    logic              grant_dc;
    logic              beat_hs;
    logic              last_beat;

    mem_arbiter_reg #(.W(2), .RESET_VAL(ARB_IDLE)) u_state_reg (
        .clk(clk), .rst_n(reset), .d(state_d), .q(state_bits_q)
    );
    mem_arbiter_reg #(.W(CNT_W), .RESET_VAL('0)) u_cnt_reg (
        .clk(clk), .rst_n(reset), .d(cnt_d), .q(cnt_q)
    );
    mem_arbiter_reg #(.W(ADDR_W), .RESET_VAL('0)) u_addr_reg (
        .clk(clk), .rst_n(reset), .d(addr_d), .q(addr_q)
    );
    mem_arbiter_reg #(.W(1), .RESET_VAL(MEM_RW_READ)) u_rw_reg (
        .clk(clk), .rst_n(reset), .d(rw_d), .q(rw_q)
    );
    mem_arbiter_reg #(.W(1), .RESET_VAL(ARB_OWNER_IC)) u_owner_reg (
        .clk(clk), .rst_n(reset), .d(owner_d), .q(owner_q)
    );

    assign state_q = arb_state_e'(state_bits_q);

    // On contention the requester that did not win last time goes first
    assign any_req  = ic_req_valid || dc_req_valid;
    assign grant_dc = dc_req_valid && (!ic_req_valid || (owner_q == ARB_OWNER_IC));

    always_comb begin
        beat_hs = 1'b0;
        case (state_q)
            ARB_WRITE: beat_hs = dc_wdata_valid && mem_req_data_ready;
            ARB_READ:  beat_hs = mem_resp_valid;
            default:   beat_hs = 1'b0;
        endcase
    end

    assign last_beat = beat_hs && (cnt_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        owner_d = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d = ARB_ISSUE;
                    cnt_d   = '0;
                    owner_d = grant_dc ? ARB_OWNER_DC : ARB_OWNER_IC;
                    addr_d  = grant_dc ? dc_req_addr : ic_req_addr;
                    rw_d    = grant_dc ? dc_req_rw : MEM_RW_READ;
                end
            end
            ARB_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = (rw_q == MEM_RW_WRITE) ? ARB_WRITE : ARB_READ;
                end
            end
            ARB_WRITE, ARB_READ: begin
                if (beat_hs) begin
                    cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
                end
                if (last_beat) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        ic_resp_valid      = 1'b0;
        ic_resp_data       = '0;
        dc_resp_valid      = 1'b0;
        dc_resp_data       = '0;
        dc_wdata_ready     = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data       = '0;
        mem_req_addr       = addr_q;
        mem_req_rw         = rw_q;
        busy               = (state_q != ARB_IDLE);
        owner              = owner_q;
        case (state_q)
            ARB_IDLE: begin
                // Ready is held low while reset is asserted even if valids are up
                ic_req_ready = reset && any_req && !grant_dc;
                dc_req_ready = reset && grant_dc;
            end
            ARB_ISSUE: begin
                mem_req_valid = 1'b1;
            end
            ARB_WRITE: begin
                mem_req_data_valid = dc_wdata_valid;
                dc_wdata_ready     = mem_req_data_ready;
                mem_req_data       = dc_wdata;
            end
            ARB_READ: begin
                if (owner_q == ARB_OWNER_IC) begin
                    ic_resp_valid = mem_resp_valid;
                    ic_resp_data  = mem_resp_valid ? mem_resp_data : '0;
                end else begin
                    dc_resp_valid = mem_resp_valid;
                    dc_resp_data  = mem_resp_valid ? mem_resp_data : '0;
                end
            end
            default: begin
                mem_req_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed tables/sequences plus random
// traffic checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW    = 28;
    localparam int DW    = 128;
    localparam int BEATS = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [AW-1:0] ic_req_addr;
    logic [DW-1:0] ic_resp_data;
    logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_wdata_valid, dc_wdata_ready, dc_resp_valid;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_wdata, dc_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data, mem_resp_data;
    logic          mem_resp_valid, busy, owner;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_rw(dc_req_rw), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
        .dc_wdata(dc_wdata), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .owner(owner)
    );

    // Single-beat build with every valid/ready tied high
    logic          s_ic_req_ready, s_ic_resp_valid, s_dc_req_ready, s_dc_wdata_ready, s_dc_resp_valid;
    logic          s_mem_req_valid, s_mem_req_rw, s_mem_req_data_valid, s_busy, s_owner;
    logic [AW-1:0] s_mem_req_addr;
    logic [DW-1:0] s_ic_resp_data, s_dc_resp_data, s_mem_req_data;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .ic_req_valid(1'b1), .ic_req_ready(s_ic_req_ready), .ic_req_addr(28'h0000123),
        .ic_resp_valid(s_ic_resp_valid), .ic_resp_data(s_ic_resp_data),
        .dc_req_valid(1'b1), .dc_req_ready(s_dc_req_ready), .dc_req_addr(28'h0000456),
        .dc_req_rw(1'b1), .dc_wdata_valid(1'b1), .dc_wdata_ready(s_dc_wdata_ready),
        .dc_wdata(128'h5), .dc_resp_valid(s_dc_resp_valid), .dc_resp_data(s_dc_resp_data),
        .mem_req_valid(s_mem_req_valid), .mem_req_ready(1'b1), .mem_req_addr(s_mem_req_addr),
        .mem_req_rw(s_mem_req_rw), .mem_req_data_valid(s_mem_req_data_valid),
        .mem_req_data_ready(1'b1), .mem_req_data(s_mem_req_data),
        .mem_resp_valid(1'b1), .mem_resp_data(128'h7),
        .busy(s_busy), .owner(s_owner)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: at most one open line transfer, a command
    // phase, then a count of outstanding beats.
    bit            m_active, m_who, m_rw, m_cmd_done, m_last, m_any, m_win;
    logic [AW-1:0] m_addr;
    int            m_left, n_txn;

    int            n_ic_beats, n_dc_beats, n_wr_hs, cyc;
    logic [DW-1:0] wr_log[$];
    bit            grant_log[$];
    int            grant_cyc[$];
    bit            ic_hs, dc_hs, wd_hs;

    task automatic model_reset();
        m_active = 0; m_cmd_done = 0; m_last = 0; m_left = 0;
    endtask

    task automatic model_check();
        bit e_icr, e_dcr, e_mv, e_dv, e_wr, e_icv, e_dcv, rd_phase;
        e_icr = 0; e_dcr = 0; e_mv = 0; e_dv = 0; e_wr = 0; e_icv = 0; e_dcv = 0;
        m_any = ic_req_valid || dc_req_valid;
        m_win = (ic_req_valid && dc_req_valid) ? !m_last : dc_req_valid;
        rd_phase = m_active && m_cmd_done && !m_rw;
        if (!m_active) begin
            e_icr = m_any && !m_win;
            e_dcr = m_any && m_win;
        end else if (!m_cmd_done) begin
            e_mv = 1;
        end else if (m_rw) begin
            e_dv = dc_wdata_valid;
            e_wr = mem_req_data_ready;
        end else begin
            e_icv = mem_resp_valid && !m_who;
            e_dcv = mem_resp_valid && m_who;
        end
        chk("ic_req_ready", ic_req_ready, e_icr);
        chk("dc_req_ready", dc_req_ready, e_dcr);
        chk("mem_req_valid", mem_req_valid, e_mv);
        chk("mem_req_data_valid", mem_req_data_valid, e_dv);
        chk("dc_wdata_ready", dc_wdata_ready, e_wr);
        chk("ic_resp_valid", ic_resp_valid, e_icv);
        chk("dc_resp_valid", dc_resp_valid, e_dcv);
        chk("busy", busy, m_active);
        chk("owner", owner, m_last);
        if (e_mv) begin
            chk("mem_req_addr", mem_req_addr, m_addr);
            chk("mem_req_rw", mem_req_rw, m_rw);
        end
        if (e_dv) chk("mem_req_data", mem_req_data, dc_wdata);
        if (e_icv) chk("ic_resp_data", ic_resp_data, mem_resp_data);
        else if (rd_phase) chk("ic_resp_data_idle", ic_resp_data, 0);
        if (e_dcv) chk("dc_resp_data", dc_resp_data, mem_resp_data);
        else if (rd_phase) chk("dc_resp_data_idle", dc_resp_data, 0);
    endtask

    task automatic model_commit();
        bit hs;
        if (!m_active) begin
            if (m_any) begin
                m_active = 1; m_who = m_win; m_last = m_win; m_cmd_done = 0; m_left = BEATS;
                m_addr = m_win ? dc_req_addr : ic_req_addr;
                m_rw = m_win && dc_req_rw;
                n_txn++;
                $display("txn %0d cyc %0d: grant %s addr=%h rw=%0d", n_txn, cyc,
                         m_win ? "DC" : "IC", m_addr, m_rw);
            end
        end else if (!m_cmd_done) begin
            if (mem_req_ready) m_cmd_done = 1;
        end else begin
            hs = m_rw ? (dc_wdata_valid && mem_req_data_ready) : mem_resp_valid;
            if (hs) begin
                m_left--;
                if (m_left == 0) m_active = 0;
            end
        end
    endtask

    // Called at the negedge with inputs stable; ends at posedge+1
    task automatic end_cycle();
        if (ic_resp_valid) n_ic_beats++;
        if (dc_resp_valid) n_dc_beats++;
        if (mem_req_data_valid && mem_req_data_ready) begin
            n_wr_hs++;
            wr_log.push_back(mem_req_data);
        end
        if (ic_req_ready) begin grant_log.push_back(1'b0); grant_cyc.push_back(cyc); end
        if (dc_req_ready) begin grant_log.push_back(1'b1); grant_cyc.push_back(cyc); end
        ic_hs = ic_req_valid && ic_req_ready;
        dc_hs = dc_req_valid && dc_req_ready;
        wd_hs = dc_wdata_valid && dc_wdata_ready;
        model_check();
        model_commit();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit            ic_v;
        bit            mrdy;
        bit            mrv;
        logic [DW-1:0] md;
        bit            e_icr;
        bit            e_mv;
        bit            e_rv;
        bit            e_busy;
    } vec_t;

    vec_t          tbl[9];
    logic [DW-1:0] wd[4];
    int            base, k_wr, ph, tx;

    initial begin
        ic_req_valid = 0; ic_req_addr = '0; dc_req_valid = 0; dc_req_addr = '0; dc_req_rw = 0;
        dc_wdata_valid = 0; dc_wdata = '0; mem_req_ready = 0; mem_req_data_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0;
        ic_hs = 0; dc_hs = 0; wd_hs = 0; cyc = 0; n_txn = 0;
        n_ic_beats = 0; n_dc_beats = 0; n_wr_hs = 0;
        model_reset();

        // IC line read with gaps; the stray beats in ISSUE and IDLE must be dropped
        tbl[0] = '{1, 0, 0, '0,                              1, 0, 0, 0};
        tbl[1] = '{0, 1, 1, 128'hDEAD,                       0, 1, 0, 1};
        tbl[2] = '{0, 0, 1, {32'hA0A0A0A0, 96'd0},           0, 0, 1, 1};
        tbl[3] = '{0, 0, 0, '0,                              0, 0, 0, 1};
        tbl[4] = '{0, 0, 1, {32'hA0A0A0A0, 96'd1},           0, 0, 1, 1};
        tbl[5] = '{0, 0, 1, {32'hA0A0A0A0, 96'd2},           0, 0, 1, 1};
        tbl[6] = '{0, 0, 0, '0,                              0, 0, 0, 1};
        tbl[7] = '{0, 0, 1, {32'hA0A0A0A0, 96'd3},           0, 0, 1, 1};
        tbl[8] = '{0, 0, 1, 128'hBEEF,                       0, 0, 0, 0};
        for (int i = 0; i < 4; i++) wd[i] = {32'hD0D0D0D0, 96'(i)};

        // Reset values, with every input that could provoke an output held high
        #1 reset = 0;
        ic_req_valid = 1; dc_req_valid = 1; mem_resp_valid = 1; mem_req_data_ready = 1; dc_wdata_valid = 1;
        #1;
        chk("rst_ic_req_ready", ic_req_ready, 0);
        chk("rst_dc_req_ready", dc_req_ready, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_ic_resp_valid", ic_resp_valid, 0);
        chk("rst_ic_resp_data", ic_resp_data, 0);
        chk("rst_dc_resp_valid", dc_resp_valid, 0);
        chk("rst_dc_wdata_ready", dc_wdata_ready, 0);
        chk("rst_mem_req_data_valid", mem_req_data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_b1_ic_req_ready", s_ic_req_ready, 0);
        chk("rst_b1_busy", s_busy, 0);
        ic_req_valid = 0; dc_req_valid = 0; mem_resp_valid = 0; mem_req_data_ready = 0; dc_wdata_valid = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1;

        // Single-beat build: DC write, IC read, ... each 3 cycles apart
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ph = k % 3;
            tx = (k / 3) % 2;
            chk("b1_mem_req_valid", s_mem_req_valid, ph == 1);
            if (ph == 1) begin
                chk("b1_mem_req_rw", s_mem_req_rw, tx == 0);
                chk("b1_mem_req_addr", s_mem_req_addr, (tx == 0) ? 28'h0000456 : 28'h0000123);
            end
            chk("b1_dc_req_ready", s_dc_req_ready, ph == 0 && tx == 0);
            chk("b1_ic_req_ready", s_ic_req_ready, ph == 0 && tx == 1);
            chk("b1_dc_wdata_ready", s_dc_wdata_ready, ph == 2 && tx == 0);
            chk("b1_mem_req_data_valid", s_mem_req_data_valid, ph == 2 && tx == 0);
            if (ph == 2 && tx == 0) chk("b1_mem_req_data", s_mem_req_data, 128'h5);
            chk("b1_ic_resp_valid", s_ic_resp_valid, ph == 2 && tx == 1);
            if (ph == 2 && tx == 1) begin
                chk("b1_ic_resp_data", s_ic_resp_data, 128'h7);
                chk("b1_dc_resp_data", s_dc_resp_data, 0);
            end
            chk("b1_dc_resp_valid", s_dc_resp_valid, 0);
            chk("b1_busy", s_busy, ph != 0);
            chk("b1_owner", s_owner, (k == 0) ? 1'b0 : (((k - 1) / 3) % 2 == 0));
            end_cycle();
        end

        // Table-driven IC read
        ic_req_addr = 28'h0000010;
        base = n_ic_beats;
        for (int i = 0; i < 9; i++) begin
            ic_req_valid = tbl[i].ic_v; mem_req_ready = tbl[i].mrdy;
            mem_resp_valid = tbl[i].mrv; mem_resp_data = tbl[i].md;
            @(negedge clk);
            chk($sformatf("tbl%0d_ic_req_ready", i), ic_req_ready, tbl[i].e_icr);
            chk($sformatf("tbl%0d_mem_req_valid", i), mem_req_valid, tbl[i].e_mv);
            if (tbl[i].e_mv) begin
                chk($sformatf("tbl%0d_addr", i), mem_req_addr, 28'h0000010);
                chk($sformatf("tbl%0d_rw", i), mem_req_rw, 0);
            end
            chk($sformatf("tbl%0d_ic_resp_valid", i), ic_resp_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_ic_resp_data", i), ic_resp_data, tbl[i].md);
            chk($sformatf("tbl%0d_dc_resp_valid", i), dc_resp_valid, 0);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            end_cycle();
        end
        chk("ic_read_beat_count", n_ic_beats - base, 4);
        mem_resp_valid = 0;

        // DCache writeback with toggling data-ready and stray read beats throughout
        dc_req_valid = 1; dc_req_addr = 28'h0000ABC; dc_req_rw = 1; mem_resp_valid = 1;
        dc_wdata_valid = 1; k_wr = 0; wd_hs = 0; dc_hs = 0;
        base = n_wr_hs; wr_log.delete();
        n_dc_beats = 0; n_ic_beats = 0;
        for (int c = 0; c < 30; c++) begin
            if (dc_hs) dc_req_valid = 0;
            if (wd_hs) k_wr++;
            if (k_wr == 4 && !busy) break;
            mem_req_ready = (c >= 2);
            mem_req_data_ready = c[0];
            dc_wdata = (k_wr < 4) ? wd[k_wr] : '0;
            mem_resp_data = 128'(c) + 128'h55;
            @(negedge clk);
            end_cycle();
        end
        chk("wb_handshakes", n_wr_hs - base, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("wb_beat%0d", i), (wr_log.size() > i) ? wr_log[i] : '0, wd[i]);
        chk("wb_idle_after", busy, 0);
        chk("wb_stray_dc_resp", n_dc_beats, 0);
        chk("wb_stray_ic_resp", n_ic_beats, 0);
        dc_wdata_valid = 0; mem_req_data_ready = 0; mem_resp_valid = 0;

        // Contention from reset: grants alternate DC, IC, DC, IC
        reset = 0; model_reset(); #2; reset = 1;
        ic_req_valid = 1; ic_req_addr = 28'h0000111;
        dc_req_valid = 1; dc_req_addr = 28'h0000222; dc_req_rw = 0;
        mem_req_ready = 1; mem_resp_valid = 1;
        grant_log.delete(); grant_cyc.delete();
        for (int c = 0; c < 60; c++) begin
            if (grant_log.size() >= 4) break;
            mem_resp_data = 128'(c) + 128'hC00;
            @(negedge clk);
            end_cycle();
        end
        chk("cont_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont_grant%0d_who", i), (grant_log.size() > i) ? grant_log[i] : 1'bx, (i % 2) == 0);
            if (i > 0 && grant_cyc.size() > i)
                chk($sformatf("cont_grant%0d_gap", i), grant_cyc[i] - grant_cyc[i-1], BEATS + 2);
        end

        // Async reset two beats into the IC read that was just granted
        ic_req_valid = 0; dc_req_valid = 0;
        base = n_ic_beats;
        for (int c = 0; c < 3; c++) begin
            mem_resp_data = {32'hB0B0B0B0, 96'(c)};
            @(negedge clk);
            end_cycle();
        end
        chk("arst_beats_before", n_ic_beats - base, 2);
        ic_req_valid = 1; ic_req_addr = 28'h0000333;
        reset = 0; model_reset();
        #1;
        chk("arst_ic_resp_valid", ic_resp_valid, 0);
        chk("arst_ic_resp_data", ic_resp_data, 0);
        chk("arst_ic_req_ready", ic_req_ready, 0);
        chk("arst_mem_req_valid", mem_req_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_owner", owner, 0);
        @(posedge clk); #1;
        reset = 1; ic_hs = 0;
        base = n_ic_beats;
        for (int c = 0; c < 20; c++) begin
            if (ic_hs) ic_req_valid = 0;
            if (c > 0 && n_ic_beats - base == 4 && !busy) break;
            mem_resp_data = {32'hE0E0E0E0, 96'(c)};
            @(negedge clk);
            end_cycle();
        end
        chk("arst_after_beats", n_ic_beats - base, 4);
        chk("arst_after_idle", busy, 0);

        // Random traffic against the model
        base = n_txn; ic_hs = 0; dc_hs = 0;
        ic_req_valid = 0; dc_req_valid = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!ic_req_valid || ic_hs) begin
                ic_req_valid = ($urandom_range(0, 2) == 0);
                ic_req_addr = AW'($urandom);
            end
            if (!dc_req_valid || dc_hs) begin
                dc_req_valid = ($urandom_range(0, 2) == 0);
                dc_req_addr = AW'($urandom);
                dc_req_rw = 1'($urandom_range(0, 1));
            end
            dc_wdata_valid = ($urandom_range(0, 3) != 0);
            dc_wdata = {$urandom, $urandom, $urandom, $urandom};
            mem_req_ready = ($urandom_range(0, 2) == 0);
            mem_req_data_ready = 1'($urandom_range(0, 1));
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            end_cycle();
        end
        chk("rand_enough_txns", (n_txn - base) >= 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
